// File: rtl/pwm_peripheral.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_peripheral: a prescaler and an 8-bit period counter build one shared
// PWM waveform. Each of the 16 registered pad outputs is off, static high or PWM.
// Optional macro PWM_DUTY_SHADOW_EN: duty is latched at each period wrap.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int             PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      out_q, out_d;
    logic             wrap_q, period_start_q;
    logic             tick;
    logic             wrap;
    logic [7:0]       duty;
    logic             pwm_sig;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    assign tick   = (pre_q == PRE_LAST);
    assign wrap   = tick && (cnt_q == 8'hFF);
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    // Latching only at the wrap keeps every period's high time self-consistent.
    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            duty_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty = duty_q;
`else
    assign duty = pwm_duty_cycle;
`endif

    always_comb begin
        pre_d = pre_q + 1'b1;
        cnt_d = cnt_q;
        if (tick) begin
            pre_d = '0;
            cnt_d = cnt_q + 8'd1;
        end
    end

    // 8'hFF is special-cased so full duty never drops low at cnt 255.
    assign pwm_sig = (duty == 8'hFF) || (cnt_q < duty);

    always_comb begin
        out_d = en_out & (~en_pwm | {16{pwm_sig}});
    end

    // wrap_q delays the pulse so it lines up with the first out sample of cnt 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q          <= '0;
            cnt_q          <= 8'h00;
            out_q          <= 16'h0000;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            wrap_q         <= wrap;
            period_start_q <= wrap_q;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pwm_peripheral: table-driven vectors plus a cycle scoreboard for pwm_peripheral.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int DIV = 13;
    localparam int P   = 256 * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty_i;
    logic [15:0] out;
    logic        period_start;

    pwm_peripheral #(.DIV(DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty_i),
        .out             (out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic        ps;
    } sb_t;

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  du;
        logic [15:0] e0;
        logic [15:0] e200;
    } vec_t;

    sb_t        sbq[$];
    int         n_pass;
    int         n_chk;
    int         cyc;
    logic [7:0] m_duty;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Expected output for the edge about to happen, from cycles elapsed since reset.
    task automatic step();
        sb_t        e;
        logic [7:0] c;
        logic [7:0] d;
        logic       pw;
        c = 8'((cyc / DIV) % 256);
`ifdef PWM_DUTY_SHADOW_EN
        d = m_duty;
        if (c == 8'hFF && (cyc % DIV) == DIV - 1) m_duty = duty_i;
`else
        d = duty_i;
`endif
        pw   = (d == 8'hFF) || (c < d);
        e.o  = en_out & (~en_pwm | {16{pw}});
        e.ps = (c == 8'd0) && ((cyc % DIV) == 0) && (cyc > 0);
        sbq.push_back(e);
        @(posedge clk);
        cyc++;
        #1;
        e = sbq.pop_front();
        chk("scoreboard", {47'd0, period_start, out}, {47'd0, e.ps, e.o});
    endtask

    task automatic align();
        step();
        for (int i = 0; i < P && (cyc % P) != 0; i++) step();
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < P + 1 && (((cyc / DIV) % 256) != c || (cyc % DIV) != 0); i++) step();
    endtask

    task automatic measure(input int n, output int hi, output int mixed);
        hi = 0;
        mixed = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out == 16'hFFFF) hi++;
            else if (out != 16'h0000) mixed++;
        end
    endtask

    initial begin
        vec_t        tbl[5];
        int          hi, mixed, cntp, bad;
        logic [15:0] prev;

        n_pass = 0;
        n_chk  = 0;
        cyc    = 0;
        m_duty = 8'h00;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 8'h80, 16'hFFFF, 16'h0000};
        tbl[1] = '{16'hFFFF, 16'h00FF, 8'h80, 16'hFFFF, 16'hFF00};
        tbl[2] = '{16'hF0F0, 16'h3C3C, 8'hFF, 16'hF0F0, 16'hF0F0};
        tbl[3] = '{16'hAAAA, 16'hFF00, 8'hC8, 16'hAAAA, 16'h00AA};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 8'hC9, 16'hFFFF, 16'hFFFF};

        // Reset with everything enabled
        rst_n  = 1'b0;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty_i = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {48'd0, out}, 64'h0);
        chk("reset_ps", {63'd0, period_start}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cntp = 0;
        for (int i = 0; i < P + 2; i++) begin
            step();
            if (period_start) cntp++;
        end
        chk("one_ps_after_reset", 64'(cntp), 64'd1);

        // Static high and enable override
        en_out = 16'h0001;
        en_pwm = 16'h0000;
        duty_i = 8'h00;
        step();
        chk("static_on", {48'd0, out}, 64'h0001);
        bad = 0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            if (out != 16'h0001) bad++;
        end
        chk("static_stable", 64'(bad), 64'd0);
        en_pwm = 16'hFF00;
        duty_i = 8'hFF;
        bad = 0;
        for (int i = 0; i < P / 2; i++) begin
            step();
            if (out[15:8] != 8'h00) bad++;
        end
        chk("en_out_overrides_pwm", 64'(bad), 64'd0);

        // Vector table: out at cnt 0 and cnt 200 of a period
        for (int k = 0; k < 5; k++) begin
            en_out = tbl[k].eo;
            en_pwm = tbl[k].ep;
            duty_i = tbl[k].du;
            align();
            step();
            chk($sformatf("vec%0d_cnt0", k), {48'd0, out}, {48'd0, tbl[k].e0});
            run_to(200);
            step();
            chk($sformatf("vec%0d_cnt200", k), {48'd0, out}, {48'd0, tbl[k].e200});
        end

        // 50% duty
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty_i = 8'h80;
        align();
        prev = out;
        step();
        chk("rise_at_period_start", {31'd0, prev, out, period_start}, {31'd0, 16'h0000, 16'hFFFF, 1'b1});
        measure(P - 1, hi, mixed);
        chk("half_high_time", 64'(hi + 1), 64'd1664);
        chk("half_bits_identical", 64'(mixed), 64'd0);

        // Duty extremes
        duty_i = 8'h00;
        align();
        measure(2 * P, hi, mixed);
        chk("duty00_high", 64'(hi + mixed), 64'd0);
        duty_i = 8'hFF;
        align();
        measure(P, hi, mixed);
        chk("dutyFF_high", 64'(hi), 64'(P));
        duty_i = 8'h01;
        align();
        measure(P, hi, mixed);
        chk("duty01_high", 64'(hi), 64'(DIV));

        // Mid-period duty change at cnt 100
        duty_i = 8'h40;
        align();
        run_to(100);
        duty_i = 8'hC0;
        step();
`ifdef PWM_DUTY_SHADOW_EN
        chk("mid_change_out", {48'd0, out}, 64'h0000);
`else
        chk("mid_change_out", {48'd0, out}, 64'hFFFF);
`endif
        hi = 0;
        for (int i = 0; i < P && (cyc % P) != 0; i++) begin
            step();
            if (out != 16'h0000) hi++;
        end
`ifdef PWM_DUTY_SHADOW_EN
        chk("mid_change_rest", 64'(hi), 64'd0);
`else
        chk("mid_change_rest", 64'(hi), 64'(92 * DIV - 1));
`endif
        measure(P, hi, mixed);
        chk("duty_C0_high", 64'(hi), 64'(192 * DIV));

        // Asynchronous reset mid-period with outputs high
        duty_i = 8'hFF;
        align();
        run_to(150);
        step();
        chk("pre_reset_high", {48'd0, out}, 64'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", {47'd0, period_start, out}, 64'h0);
        duty_i = 8'h80;
        @(negedge clk);
        rst_n  = 1'b1;
        cyc    = 0;
        m_duty = 8'h00;
        step();
`ifdef PWM_DUTY_SHADOW_EN
        chk("first_rise_after_rst", {48'd0, out}, 64'h0000);
`else
        chk("first_rise_after_rst", {48'd0, out}, 64'hFFFF);
`endif
        cntp = 1;
        for (int i = 0; i < P + 10 && !period_start; i++) begin
            step();
            cntp++;
        end
        chk("first_ps_after_rst", 64'(cntp), 64'(P + 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
